// File: rtl/win_pkg.sv
// Shared defaults and types for the 3x3 window generator.
package win_pkg;

    localparam int PIX_W_DEF = 8;
    localparam int IMG_W_DEF = 640;
    localparam int COORD_W   = 11;

    typedef logic [PIX_W_DEF-1:0] pix_t;

endpackage

// File: rtl/line_buffer.sv
// One image line of pixel storage: combinational read, synchronous write.
module line_buffer
    import win_pkg::*;
#(
    parameter int DEPTH = IMG_W_DEF,
    parameter int PIX_W = PIX_W_DEF,
    parameter int AW    = (DEPTH > 2) ? $clog2(DEPTH) : 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [PIX_W-1:0] wr_data,
    output logic [PIX_W-1:0] rd_data
);

    logic [PIX_W-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    // Contents are deliberately not reset; window gating hides stale data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/window_3x3_gen.sv
// Streaming 3x3 neighbourhood generator over two line buffers.
// Optional window-centre coordinate outputs are enabled by defining WIN_COORD_EN.
module window_3x3_gen
    import win_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PIX_W-1:0]   pix_in,
    input  logic               pix_valid,
    input  logic               sof,
    output logic [PIX_W-1:0]   c1,
    output logic [PIX_W-1:0]   c2,
    output logic [PIX_W-1:0]   c3,
    output logic [PIX_W-1:0]   c4,
    output logic [PIX_W-1:0]   c5,
    output logic [PIX_W-1:0]   c6,
    output logic [PIX_W-1:0]   c7,
    output logic [PIX_W-1:0]   c8,
    output logic [PIX_W-1:0]   c9,
`ifdef WIN_COORD_EN
    output logic [COORD_W-1:0] win_x,
    output logic [COORD_W-1:0] win_y,
`endif
    output logic               win_valid
);

    localparam int XW = (IMG_W > 2) ? $clog2(IMG_W) : 2;

    logic [XW-1:0]      x, x_cur, x_nxt;
    logic [COORD_W-1:0] y, y_cur, y_nxt;
    logic [PIX_W-1:0]   rd0, rd1;
    logic               we;

    // A pixel presented together with reset is dropped, including its line-buffer write.
    assign we    = pix_valid & ~rst;
    assign x_cur = sof ? '0 : x;
    assign y_cur = sof ? '0 : y;

    always_comb begin
        x_nxt = x_cur + XW'(1);
        y_nxt = y_cur;
        if (x_cur == XW'(IMG_W - 1)) begin
            x_nxt = '0;
            if (y_cur != '1) begin
                y_nxt = y_cur + COORD_W'(1);
            end
        end
    end

    line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W), .AW(XW)) lb0 (
        .clk     (clk),
        .we      (we),
        .addr    (x_cur),
        .wr_data (pix_in),
        .rd_data (rd0)
    );

    line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W), .AW(XW)) lb1 (
        .clk     (clk),
        .we      (we),
        .addr    (x_cur),
        .wr_data (rd0),
        .rd_data (rd1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            x         <= '0;
            y         <= '0;
            win_valid <= 1'b0;
            {c1, c2, c3, c4, c5, c6, c7, c8, c9} <= '0;
`ifdef WIN_COORD_EN
            win_x     <= '0;
            win_y     <= '0;
`endif
        end else begin
            win_valid <= 1'b0;
            if (pix_valid) begin
                x         <= x_nxt;
                y         <= y_nxt;
                c1        <= c2;
                c2        <= c3;
                c3        <= rd1;
                c4        <= c5;
                c5        <= c6;
                c6        <= rd0;
                c7        <= c8;
                c8        <= c9;
                c9        <= pix_in;
                win_valid <= (y_cur >= COORD_W'(2)) && (x_cur >= XW'(2));
`ifdef WIN_COORD_EN
                win_x     <= COORD_W'(x_cur) - COORD_W'(1);
                win_y     <= y_cur - COORD_W'(1);
`endif
            end
        end
    end

endmodule

// File: tb/tb_window_3x3_gen.sv
// Self-checking bench for window_3x3_gen with a per-column history reference model.
module tb_window_3x3_gen;
    import win_pkg::*;

    localparam int IMG_W = 4;
    localparam int PIX_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [PIX_W-1:0] pix_in = '0;
    logic             pix_valid = 1'b0;
    logic             sof = 1'b0;
    logic [PIX_W-1:0] c1, c2, c3, c4, c5, c6, c7, c8, c9;
    logic             win_valid;
`ifdef WIN_COORD_EN
    logic [10:0]      win_x, win_y;
`endif

    window_3x3_gen #(.IMG_W(IMG_W), .PIX_W(PIX_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .pix_in    (pix_in),
        .pix_valid (pix_valid),
        .sof       (sof),
        .c1        (c1),
        .c2        (c2),
        .c3        (c3),
        .c4        (c4),
        .c5        (c5),
        .c6        (c6),
        .c7        (c7),
        .c8        (c8),
        .c9        (c9),
`ifdef WIN_COORD_EN
        .win_x     (win_x),
        .win_y     (win_y),
`endif
        .win_valid (win_valid)
    );

    always #5 clk = ~clk;

    pix_t taps [9];
    assign taps[0] = c1;
    assign taps[1] = c2;
    assign taps[2] = c3;
    assign taps[3] = c4;
    assign taps[4] = c5;
    assign taps[5] = c6;
    assign taps[6] = c7;
    assign taps[7] = c8;
    assign taps[8] = c9;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: raster position, per-column history of the last two lines, tap grid.
    int  mtap [9];
    int  hist0 [IMG_W];
    int  hist1 [IMG_W];
    int  frame_rows [3][IMG_W];
    int  mcol, mrow, mlx, mly, mwx, mwy;
    bit  mvalid;

    task automatic cycle(input int pix, input bit v, input bit s, input bit r);
        int ex, ey;
        pix_in    = pix[7:0];
        pix_valid = v;
        sof       = s;
        rst       = r;
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 9; i++) mtap[i] = 0;
            mvalid = 0; mcol = 0; mrow = 0; mwx = 0; mwy = 0;
        end else if (v) begin
            ex = s ? 0 : mcol;
            ey = s ? 0 : mrow;
            for (int k = 0; k < 3; k++) begin
                mtap[3*k]   = mtap[3*k+1];
                mtap[3*k+1] = mtap[3*k+2];
            end
            mtap[2] = hist1[ex];
            mtap[5] = hist0[ex];
            mtap[8] = pix;
            hist1[ex] = hist0[ex];
            hist0[ex] = pix;
            frame_rows[ey % 3][ex] = pix;
            mvalid = (ey >= 2) && (ex >= 2);
            mlx = ex; mly = ey;
            mwx = (ex - 1) & 2047;
            mwy = (ey - 1) & 2047;
            mcol = ex + 1;
            mrow = ey;
            if (mcol == IMG_W) begin
                mcol = 0;
                if (ey < 2047) mrow = ey + 1;
            end
        end else begin
            mvalid = 0;
        end
        #1;
    endtask

    task automatic test_reset;
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        n_tests++;
        if (win_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset win_valid: got %b expected 0", win_valid);
        end
        for (int i = 0; i < 9; i++) begin
            n_tests++;
            if (taps[i] !== 8'h00) begin
                n_fail++; $display("FAIL reset c%0d: got %02h expected 00", i + 1, taps[i]);
            end
        end
`ifdef WIN_COORD_EN
        n_tests++;
        if (win_x !== 11'd0 || win_y !== 11'd0) begin
            n_fail++; $display("FAIL reset coords: got (%0d,%0d) expected (0,0)", win_x, win_y);
        end
`endif
    endtask

    // Full 4x4 frame; optional 3-cycle bubble after pixel 0x21.
    task automatic run_frame(input string name, input bit bubbles);
        int strobes = 0;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
                cycle(16 * y + x, 1, (y == 0 && x == 0), 0);
                if (win_valid === 1'b1) strobes++;
                n_tests++;
                if (win_valid !== ((y >= 2) && (x >= 2))) begin
                    n_fail++;
                    $display("FAIL %s valid at %02h: got %b expected %b", name, 16 * y + x, win_valid, (y >= 2) && (x >= 2));
                end
                if (y >= 2 && x >= 2) begin
                    for (int k = 0; k < 9; k++) begin
                        n_tests++;
                        if (taps[k] !== 8'(16 * (y - 2 + k / 3) + (x - 2 + k % 3))) begin
                            n_fail++;
                            $display("FAIL %s tap c%0d at %02h: got %02h expected %02h", name, k + 1, 16 * y + x, taps[k], 16 * (y - 2 + k / 3) + (x - 2 + k % 3));
                        end
                    end
                end
                if (bubbles && y == 2 && x == 1) begin
                    for (int b = 0; b < 3; b++) begin
                        cycle($urandom_range(0, 255), 0, $urandom_range(0, 1), 0);
                        n_tests++;
                        if (win_valid !== 1'b0) begin
                            n_fail++; $display("FAIL %s bubble valid: got %b expected 0", name, win_valid);
                        end
                        for (int k = 0; k < 9; k++) begin
                            if (mtap[k] >= 0) begin
                                n_tests++;
                                if (taps[k] !== 8'(mtap[k])) begin
                                    n_fail++; $display("FAIL %s bubble hold c%0d: got %02h expected %02h", name, k + 1, taps[k], mtap[k]);
                                end
                            end
                        end
                    end
                end
            end
        end
        n_tests++;
        if (strobes != 4) begin
            n_fail++; $display("FAIL %s strobe count: got %0d expected 4", name, strobes);
        end
        cycle(0, 0, 0, 0);
    endtask

    task automatic test_frame_gapless;
        run_frame("gapless", 0);
    endtask

    task automatic test_bubbles;
        run_frame("bubbles", 1);
    endtask

    // Ten pixels after the restart pixel must pass before the new (2,2) window.
    task automatic check_restart(input string name, input bit use_sof);
        for (int k = 0; k <= 10; k++) begin
            cycle(16 * (k / 4) + (k % 4), 1, (use_sof && k == 0), 0);
            n_tests++;
            if (win_valid !== (k == 10)) begin
                n_fail++; $display("FAIL %s valid after %0d: got %b expected %b", name, k, win_valid, k == 10);
            end
        end
        for (int k = 0; k < 9; k++) begin
            n_tests++;
            if (taps[k] !== 8'(16 * (k / 3) + (k % 3))) begin
                n_fail++; $display("FAIL %s tap c%0d: got %02h expected %02h", name, k + 1, taps[k], 16 * (k / 3) + (k % 3));
            end
        end
        cycle(0, 0, 0, 0);
    endtask

    task automatic test_sof_restart;
        for (int k = 0; k < 6; k++) cycle(8'h80 + 16 * (k / 4) + (k % 4), 1, (k == 0), 0);
        check_restart("sof_restart", 1);
    endtask

    task automatic test_reset_midrow;
        for (int k = 0; k < 10; k++) cycle(8'hC0 + 16 * (k / 4) + (k % 4), 1, (k == 0), 0);
        cycle(8'hEE, 1, 0, 1);
        n_tests++;
        if (win_valid !== 1'b0 || {c1, c2, c3, c4, c5, c6, c7, c8, c9} !== '0) begin
            n_fail++; $display("FAIL reset_midrow zero: got valid %b taps %h expected all 0", win_valid, {c1, c2, c3, c4, c5, c6, c7, c8, c9});
        end
        check_restart("reset_midrow", 0);
    endtask

`ifdef WIN_COORD_EN
    task automatic test_coords;
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
                cycle(16 * y + x, 1, (y == 0 && x == 0), 0);
                if ((y == 2 && x == 2) || (y == 3 && x == 2)) begin
                    n_tests++;
                    if (win_x !== 11'd1 || win_y !== 11'(y - 1)) begin
                        n_fail++; $display("FAIL coords at %02h: got (%0d,%0d) expected (1,%0d)", 16 * y + x, win_x, win_y, y - 1);
                    end
                end
            end
        end
        cycle(0, 0, 0, 0);
    endtask
`endif

    task automatic test_random;
        bit r, v, s;
        for (int n = 0; n < 600; n++) begin
            r = ($urandom_range(0, 99) < 2);
            v = ($urandom_range(0, 3) != 0);
            s = v && ($urandom_range(0, 99) < 4);
            cycle($urandom_range(0, 255), v, s, r);
            n_tests++;
            if (win_valid !== mvalid) begin
                n_fail++; $display("FAIL random valid cycle %0d: got %b expected %b", n, win_valid, mvalid);
            end
            for (int k = 0; k < 9; k++) begin
                if (mtap[k] >= 0) begin
                    n_tests++;
                    if (taps[k] !== 8'(mtap[k])) begin
                        n_fail++; $display("FAIL random tap c%0d cycle %0d: got %02h expected %02h", k + 1, n, taps[k], mtap[k]);
                    end
                end
            end
            if (mvalid) begin
                for (int k = 0; k < 9; k++) begin
                    n_tests++;
                    if (taps[k] !== 8'(frame_rows[(mly - 2 + k / 3) % 3][mlx - 2 + k % 3])) begin
                        n_fail++;
                        $display("FAIL random window c%0d cycle %0d: got %02h expected %02h", k + 1, n, taps[k], frame_rows[(mly - 2 + k / 3) % 3][mlx - 2 + k % 3]);
                    end
                end
            end
`ifdef WIN_COORD_EN
            n_tests++;
            if (win_x !== 11'(mwx) || win_y !== 11'(mwy)) begin
                n_fail++; $display("FAIL random coords cycle %0d: got (%0d,%0d) expected (%0d,%0d)", n, win_x, win_y, mwx, mwy);
            end
`endif
        end
    endtask

    initial begin
        for (int i = 0; i < IMG_W; i++) begin
            hist0[i] = -1;
            hist1[i] = -1;
        end
        for (int i = 0; i < 9; i++) mtap[i] = 0;
        mcol = 0; mrow = 0; mlx = 0; mly = 0; mwx = 0; mwy = 0; mvalid = 0;
        test_reset();
        test_frame_gapless();
        test_bubbles();
        test_sof_restart();
        test_reset_midrow();
`ifdef WIN_COORD_EN
        test_coords();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/window_3x3_gen.md
# window_3x3_gen

Streaming 3×3 neighbourhood generator for the edge-preserving filter datapath. It accepts raster-order 8-bit pixels, buffers the two previous image lines and presents the nine window taps `c1..c9` together with a qualifying strobe. These taps are the producer-side feed for the nine-input pipelined pixel-sum stage and the other filter kernels. Border windows are suppressed; only fully populated windows are flagged valid.

## Interface
- `IMG_W`, default 640: active pixels per line; must be ≥ 3.
- `PIX_W`, default 8: pixel width in bits.
- `clk`, in, 1: single clock; every register changes only on its rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `pix_in`, in, `PIX_W`: incoming pixel, raster order.
- `pix_valid`, in, 1: `pix_in` is accepted on this edge. There is no backpressure.
- `sof`, in, 1: start of frame; meaningful only while `pix_valid` is high.
- `c1..c9`, out, `PIX_W` each: window taps, registered.
  - Row order: `c1..c3` are the oldest line, `c4..c6` the middle line, `c7..c9` the current line.
  - Column order within each row: left to right.
  - `c9` is the newest pixel.
- `win_valid`, out, 1: taps form a complete 3×3 window. It is a one-cycle strobe per window.
- `win_x`, `win_y`, out, 11 each: centre coordinate of the window. Present only with `WIN_COORD_EN`.

## Operation
- Column counter `x` counts 0..`IMG_W`-1.
- Row counter `y` is 11 bits and saturates at 2047.
- Each accepted pixel (`pix_valid`=1):
  - Combinational read of `lb0[x]` (previous line) and `lb1[x]` (line before that).
  - Write `lb1[x]` ← `lb0[x]` and `lb0[x]` ← `pix_in`, read-before-write.
  - Shift the three tap rows left by one. New right column: `c3`←`lb1[x]`, `c6`←`lb0[x]`, `c9`←`pix_in`.
  - `x` increments. At `IMG_W`-1 it wraps to 0 and `y` increments.
  - `win_valid` ← (`y` ≥ 2) and (`x` ≥ 2), evaluated for the pixel being accepted.
- `sof` with `pix_valid`: the pixel is treated as (0,0). Counters load x=1, y=0 afterwards. Line-buffer contents are not cleared, because windows are gated by `y`.
- `pix_valid`=0 (bubble): counters, taps and line buffers hold, and `win_valid`=0. A stream with bubbles yields the same window sequence as the gapless stream.
- Row boundary: the two accepted pixels with x=0 and x=1 never assert `win_valid`, even though their taps straddle lines.
- Window count per frame is (`IMG_W`−2)×(H−2).
- The frame height H is not a parameter. The stream simply continues until the next `sof`.

## Timing
- Latency: a pixel accepted at edge t makes its taps and `win_valid` visible after edge t, i.e. one cycle.
- Throughput: one pixel per clock sustained.
- Reset values:
  - `c1..c9` = 0, `win_valid` = 0, `win_x` = `win_y` = 0.
  - `x` = 0 and `y` = 0.
  - Line buffers are not reset.
- Reset mid-frame: the next accepted pixel is treated as (0,0), identical to `sof`.
- `rst` and `pix_valid` high together: reset wins and the pixel is dropped.

## Configuration
- `WIN_COORD_EN` defined: the `win_x`/`win_y` ports exist. They are registered alongside the taps and give the window centre (x−1, y−1) of the newest pixel. They update only on accepted pixels.
- `WIN_COORD_EN` not defined: the ports and their registers are absent. All other behaviour is identical.

## Structure
- Shared package `win_pkg` holds:
  - `PIX_W` default;
  - `IMG_W` default;
  - `COORD_W` = 11;
  - typedef `pix_t`.
- Sub-module `line_buffer`: `IMG_W` × `PIX_W` storage with combinational read and synchronous write on `we`. It is instantiated twice (`lb0`, `lb1`).
- Top level contains the counters, the tap shift registers and the valid/coordinate logic.

## Test plan
All scenarios use `IMG_W`=4 and pixel value = 16·y + x.
1. Reset, then `sof` and three gapless rows. The first `win_valid` appears one cycle after pixel 0x22, with `c1..c9` = 00,01,02,10,11,12,20,21,22. A second window follows with taps 01..23.
2. Row wrap: pixels 0x30 and 0x31 give no `win_valid`. Pixel 0x32 gives taps 10,11,12,20,21,22,30,31,32. A 4×4 frame yields exactly 4 strobes.
3. Bubbles: drop `pix_valid` for 3 cycles after pixel 0x21. Outputs hold and `win_valid`=0 throughout. The resulting window sequence is identical to scenario 1.
4. `sof` reasserted on the 7th pixel of a frame: no `win_valid` until 10 further pixels are accepted (the new (2,2)). That window's taps contain only post-`sof` data.
5. `rst` pulsed mid-row 2: all outputs read 0 the next cycle. Behaviour afterwards matches scenario 4. A pixel presented with `rst` high is ignored.
6. `WIN_COORD_EN`, scenario 1 stimulus: the first window reports `win_x`=1, `win_y`=1. The window after pixel 0x32 reports (1,2).
